memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  Pipeline stage directly downstream of execute. Consumes execute's registered outputs and performs the
//  data-memory load/store over a variable-latency req/ack interface. Selects the writeback value and
//  registers the MEM/WB pipeline outputs. Asserts stallOut upstream while a memory access is outstanding.
// PARAMETERS
//  MAX_WAIT  8  cycles in WAIT without memAck before the access is abandoned and errOut is raised (1..255)
// PORTS
//  clk          in   1   clock; one clock domain, all flops rising-edge
//  rst          in   1   reset, asynchronous, active-low
//  instr        in   16  instruction from execute; 16'h0800 = bubble
//  nextPc       in   16  PC+2 of the instruction
//  aluOut       in   16  ALU result; memory address for loads/stores
//  reg2Data     in   16  store data
//  setVal       in   16  set-instruction result
//  memEn        in   1   access memory this instruction
//  memWrt       in   1   access is a store (valid only with memEn)
//  regWrt       in   1   instruction writes the register file
//  regWrtSrc    in   3   writeback source: 0 ALU, 1 MEM, 2 nextPc, 3 setVal, 4-7 illegal
//  writeReg     in   3   destination register
//  halt         in   1   halt request
//  errIn        in   1   error from execute
//  memReq       out  1   memory request; held high until memAck
//  memWr        out  1   1 = write, 0 = read; stable while memReq
//  memAddr      out  16  address; stable while memReq
//  memWData     out  16  write data; stable while memReq
//  memRData     in   16  read data; valid when memAck
//  memAck       in   1   access complete; may arrive in the same cycle as memReq (zero-wait)
//  stallOut     out  1   freeze upstream stages
//  instrOut     out  16  registered instr; 16'h0800 on bubble
//  wrtData      out  16  registered writeback value
//  regWrtOut    out  1   registered regWrt, gated
//  writeRegOut  out  3   registered writeReg
//  haltOut      out  1   registered halt, gated
//  errOut       out  1   registered error: errIn | illegal regWrtSrc | timeout
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, waitCnt=0, all registered outputs 0 except instrOut=16'h0800; memReq=0 at once.
//  FSM states:
//   IDLE: if memEn=0, complete the instruction: register outputs next edge (latency 1), stallOut=0.
//     If memEn=1: memReq=1 combinationally with memAddr=aluOut, memWData=reg2Data, memWr=memWrt.
//     Capture instr, nextPc, aluOut, reg2Data, setVal, ctl, writeReg, halt and errIn into holding regs.
//     If memAck=1 in the same cycle: complete, stay IDLE, stallOut=0.
//     If memAck=0: stallOut=1, go to WAIT.
//   WAIT: memReq=1; memAddr, memWData and memWr driven from holding regs.
//     Inputs are ignored because execute zeroes its controls during stall. stallOut=1 until memAck.
//     memAck=1: stallOut=0, complete from holding regs (load data = memRData), go to IDLE.
//     waitCnt counts WAIT cycles. At MAX_WAIT without ack: complete with errOut=1, regWrtOut=0, go to IDLE.
//  Cycles that do not complete (each WAIT cycle before ack) drive a bubble on the outputs.
//   Bubble: regWrtOut=0, haltOut=0, instrOut=16'h0800, errOut=0.
//  wrtData mux: 0 aluOut, 1 memRData (loads), 2 nextPc, 3 setVal.
//   regWrtSrc 4-7 with regWrt=1: errOut=1, regWrtOut=0, wrtData=0.
//  memAck while memReq=0 is ignored. memAck simultaneous with timeout: the ack wins and no error is raised.
//  Store: regWrtOut follows regWrt (normally 0). Load data is taken only on the ack cycle.
//  Halt: haltOut=1 only on the completing cycle of the halting instruction.
//   After haltOut, the stage completes no new memory requests.
//  Reset mid-WAIT: memReq drops asynchronously and the outstanding access is abandoned.
// STRUCTURE
//  Shared package: regWrtSrc encodings, NOP instr 16'h0800, IDLE/WAIT state encodings.
//  One sub-module: mem_req_fsm (IDLE/WAIT, waitCnt, stallOut, memReq, capture enable).
//  Datapath (holding regs, mux, output regs) stays in memory_stage, built from dffEn with async active-low reset.
// TESTING
//  1. ALU op: regWrtSrc=0, aluOut=16'h1234, regWrt=1, memEn=0.
//     -> next edge: wrtData=16'h1234, regWrtOut=1, stallOut never 1.
//  2. Zero-wait load: memEn=1, memWrt=0, aluOut=16'h0040, memAck in the same cycle, memRData=16'hBEEF.
//     -> memReq one cycle, memAddr=16'h0040, no stall, wrtData=16'hBEEF.
//  3. Store with 3-cycle ack: reg2Data=16'h00AA, aluOut=16'h0010, upstream inputs zeroed after cycle 1.
//     -> memAddr=0010 and memWData=00AA stable for 3 cycles, stallOut=1 for 2 cycles.
//     -> bubbles during the wait, then regWrtOut=0 on completion.
//  4. No ack with MAX_WAIT=8.
//     -> memReq high for 9 cycles (issue plus 8 WAIT), then errOut=1 on completion, FSM back to IDLE.
//     -> ack exactly at the MAX_WAIT cycle instead -> errOut=0.
//  5. rst pulsed low mid-WAIT.
//     -> memReq=0 immediately, instrOut=16'h0800, all outputs 0.
//     -> next load after release completes normally.
//  6. halt on a load with a 2-cycle ack, regWrtSrc=5 on a later op.
//     -> haltOut pulses once, on the completion cycle.
//     -> the illegal-source op yields errOut=1, regWrtOut=0.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory pipeline stage: writeback-source codes,
// the bubble instruction, FSM state encoding and the captured-instruction bundle.
package memory_stage_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC  = 3'd2;
  localparam logic [2:0] WB_SET = 3'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Everything the stage needs to finish an instruction after execute has moved on.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] next_pc;
    logic [15:0] alu_out;
    logic [15:0] reg2_data;
    logic [15:0] set_val;
    logic        mem_wrt;
    logic        reg_wrt;
    logic [2:0]  wb_src;
    logic [2:0]  write_reg;
    logic        halt;
    logic        err_in;
  } stage_op_t;

  function automatic logic is_illegal_src(input logic [2:0] src);
    return src > WB_SET;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus. The stage is the master; the memory
// (or its model) is the slave and may acknowledge in the request cycle.
interface memory_stage_if;
  logic        memReq;
  logic        memWr;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData;
  logic        memAck;

  modport master (
    output memReq, memWr, memAddr, memWData,
    input  memRData, memAck
  );

  modport slave (
    input  memReq, memWr, memAddr, memWData,
    output memRData, memAck
  );
endinterface

// File: rtl/dffEn.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module dffEn #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // NOTE: non-blocking assignment so every flop samples pre-edge values,
  // independent of the order in which always blocks are evaluated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      o_q <= RST_VAL;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/mem_req_fsm.sv
// Request controller for the memory stage: IDLE/WAIT sequencing, wait-cycle
// timeout, upstream stall, holding-register capture and post-halt lockout.
module mem_req_fsm
  import memory_stage_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_mem_en,
  input  logic i_ack,
  input  logic i_halt,
  output logic o_req,
  output logic o_stall,
  output logic o_capture,
  output logic o_complete,
  output logic o_timeout,
  output logic o_in_wait
);

  localparam logic [7:0] LP_LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e     r_state, w_next_state;
  logic [7:0] r_wait_cnt, w_wait_cnt_next;
  logic       r_halted, w_halted_next;
  logic       w_last_wait;

  assign w_last_wait = (r_wait_cnt == LP_LAST_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
      r_halted   <= w_halted_next;
    end
  end

  // Once a halting instruction retires, later memory instructions are dropped.
  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = '0;
    w_halted_next   = r_halted | (o_complete & i_halt);
    case (r_state)
      ST_IDLE: begin
        if (i_mem_en && !r_halted && !i_ack) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ack || w_last_wait) w_next_state = ST_IDLE;
        else                      w_wait_cnt_next = r_wait_cnt + 8'd1;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_req      = 1'b0;
    o_stall    = 1'b0;
    o_capture  = 1'b0;
    o_complete = 1'b0;
    o_timeout  = 1'b0;
    o_in_wait  = (r_state == ST_WAIT);
    case (r_state)
      ST_IDLE: begin
        if (!i_mem_en) begin
          o_complete = 1'b1;
        end else if (!r_halted) begin
          o_req      = 1'b1;
          o_capture  = 1'b1;
          o_complete = i_ack;
          o_stall    = !i_ack;
        end
      end
      ST_WAIT: begin
        o_req = 1'b1;
        if (i_ack) begin
          o_complete = 1'b1;
        end else if (w_last_wait) begin
          o_complete = 1'b1;
          o_timeout  = 1'b1;
        end else begin
          o_stall = 1'b1;
        end
      end
      default: ;
    endcase
    // Request and stall are combinational from live inputs; reset must kill
    // them immediately rather than waiting for the state flop to settle.
    if (!rst) begin
      o_req   = 1'b0;
      o_stall = 1'b0;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives the data-memory bus, holds the instruction across a
// variable-latency access, selects the writeback value and registers MEM/WB.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          instr,
  input  logic [15:0]          nextPc,
  input  logic [15:0]          aluOut,
  input  logic [15:0]          reg2Data,
  input  logic [15:0]          setVal,
  input  logic                 memEn,
  input  logic                 memWrt,
  input  logic                 regWrt,
  input  logic [2:0]           regWrtSrc,
  input  logic [2:0]           writeReg,
  input  logic                 halt,
  input  logic                 errIn,
  memory_stage_if.master       mem,
  output logic                 stallOut,
  output logic [15:0]          instrOut,
  output logic [15:0]          wrtData,
  output logic                 regWrtOut,
  output logic [2:0]           writeRegOut,
  output logic                 haltOut,
  output logic                 errOut
);

  stage_op_t   w_live;
  stage_op_t   r_hold;
  stage_op_t   w_src;
  logic        w_req, w_capture, w_complete, w_timeout, w_in_wait;
  logic        w_illegal;
  logic [15:0] w_wb_data;
  logic [15:0] w_instr_d;
  logic [2:0]  w_flags_d, w_flags_q;
  logic [18:0] w_wb_q;

  always_comb begin
    w_live.instr     = instr;
    w_live.next_pc   = nextPc;
    w_live.alu_out   = aluOut;
    w_live.reg2_data = reg2Data;
    w_live.set_val   = setVal;
    w_live.mem_wrt   = memWrt;
    w_live.reg_wrt   = regWrt;
    w_live.wb_src    = regWrtSrc;
    w_live.write_reg = writeReg;
    w_live.halt      = halt;
    w_live.err_in    = errIn;
  end

  // During WAIT execute has zeroed its outputs, so everything comes from the holding regs.
  assign w_src = w_in_wait ? r_hold : w_live;

  mem_req_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_mem_en   (memEn),
    .i_ack      (mem.memAck),
    .i_halt     (w_src.halt),
    .o_req      (w_req),
    .o_stall    (stallOut),
    .o_capture  (w_capture),
    .o_complete (w_complete),
    .o_timeout  (w_timeout),
    .o_in_wait  (w_in_wait)
  );

  dffEn #(.WIDTH($bits(stage_op_t))) u_hold (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_capture),
    .i_d  (w_live),
    .o_q  (r_hold)
  );

  assign mem.memReq   = w_req;
  assign mem.memWr    = w_src.mem_wrt;
  assign mem.memAddr  = w_src.alu_out;
  assign mem.memWData = w_src.reg2_data;

  assign w_illegal = w_src.reg_wrt & is_illegal_src(w_src.wb_src);

  // Illegal sources fall into the default arm, giving the required zero.
  always_comb begin
    w_wb_data = '0;
    case (w_src.wb_src)
      WB_ALU:  w_wb_data = w_src.alu_out;
      WB_MEM:  w_wb_data = mem.memRData;
      WB_PC:   w_wb_data = w_src.next_pc;
      WB_SET:  w_wb_data = w_src.set_val;
      default: w_wb_data = '0;
    endcase
  end

  // Non-completing cycles load a bubble into the control outputs.
  assign w_instr_d = w_complete ? w_src.instr : NOP_INSTR;
  assign w_flags_d = {w_complete & w_src.reg_wrt & ~w_illegal & ~w_timeout,
                      w_complete & w_src.halt,
                      w_complete & (w_src.err_in | w_illegal | w_timeout)};

  dffEn #(.WIDTH(16), .RST_VAL(NOP_INSTR)) u_instr_out (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_instr_d),
    .o_q  (instrOut)
  );

  dffEn #(.WIDTH(3)) u_flags_out (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_flags_d),
    .o_q  (w_flags_q)
  );

  dffEn #(.WIDTH(19)) u_wb_out (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_complete),
    .i_d  ({w_wb_data, w_src.write_reg}),
    .o_q  (w_wb_q)
  );

  assign regWrtOut   = w_flags_q[2];
  assign haltOut     = w_flags_q[1];
  assign errOut      = w_flags_q[0];
  assign wrtData     = w_wb_q[18:3];
  assign writeRegOut = w_wb_q[2:0];

endmodule
